// File: rtl/cla_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_seq_pkg
//  Description : Shared types and helpers for the sequential CLA adder.
//                - state_t   : controller state encoding (IDLE, RUN, DONE)
//                - NIB_W     : width of one nibble pass (4 bits)
//                - nib_count : number of nibble passes for a given width
//  Revision    : 1.0  initial release
// ============================================================================
package cla_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_nibble.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble
//  Description : Purely combinational 4-bit carry-lookahead adder.
//  Ports       : a[3:0], b[3:0] - addends
//                ci             - carry in
//                s[3:0]         - sum
//                co             - carry out of bit 3
//  Revision    : 1.0  initial release
// ============================================================================
module cla_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is expanded in terms of P/G and ci so no carry depends on
    // a previously computed internal carry.
    assign w_c1 = w_g[0]
                | (w_p[0] & ci);
    assign w_c2 = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & ci);
    assign w_c3 = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co   = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s = w_p ^ {w_c3, w_c2, w_c1, ci};

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cla_seq_adder_ctrl
//  Description : WIDTH-bit adder built from one shared 4-bit CLA nibble,
//                one nibble per clock, LSB first, carry chained through a
//                register. Valid/ready handshake on operands and result.
//  Parameters  : WIDTH - operand width, multiple of 4 and >= 8
//  Options     : CLA_SEQ_SUB_EN - adds 'sub' input (a-b) and 'ovf' output
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                in_valid/in_ready     - operand handshake
//                a, b, cin             - operands, carry in
//                sub (opt)             - subtract request, latched at accept
//                out_valid/out_ready   - result handshake
//                sum, cout             - result, carry out of MSB
//                ovf (opt)             - signed overflow of the result
//                busy                  - high in RUN or DONE
//  Revision    : 1.0  initial release
// ============================================================================
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SEQ_SUB_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_idx;
`ifdef CLA_SEQ_SUB_EN
    logic             r_ovf;
`endif

    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_s;
    logic             w_co;

    // Nibble select for the current pass.
    assign w_a_nib = r_a[r_idx*NIB_W +: NIB_W];
    assign w_b_nib = r_b[r_idx*NIB_W +: NIB_W];

    cla_nibble u_nibble (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
`ifdef CLA_SEQ_SUB_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
`ifdef CLA_SEQ_SUB_EN
                        // a - b == a + ~b + 1; cin is ignored when subtracting.
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_b     <= b;
                        r_carry <= cin;
`endif
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_sum[r_idx*NIB_W +: NIB_W] <= w_s;
                    r_carry                     <= w_co;
                    if (r_idx == c_idx_last) begin
                        r_idx       <= '0;
                        r_cout      <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef CLA_SEQ_SUB_EN
                        // Signed overflow: carry into the MSB differs from the
                        // carry out of it. Carry into bit 3 is recovered as
                        // s ^ a ^ b at that bit.
                        r_ovf <= w_co ^ (w_s[NIB_W-1] ^ w_a_nib[NIB_W-1]
                                                      ^ w_b_nib[NIB_W-1]);
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef CLA_SEQ_SUB_EN
    assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire
